// File: rtl/teller_dispatcher.sv
// Round-robin call of the queue head to a free open desk; call latency 1 cycle from eligibility, pop 1 cycle after ack.
// Call is held until call_ack or cancel. Optional service timeout via DISPATCH_TIMEOUT_EN.
module teller_dispatcher #(
    parameter int MAX_SERVICE = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] queue_count,
    input  logic [2:0] teller_open,
    input  logic [2:0] teller_done,
    input  logic       call_ack,
    output logic       call_valid,
    output logic [1:0] call_teller,
    output logic       pop,
    output logic [2:0] teller_busy,
    output logic [1:0] active_tellers,
    output logic       no_service,
    output logic [2:0] timeout
);

    typedef enum logic [1:0] {IDLE, CALL, HOLD} state_t;

    state_t     state_q;
    logic [1:0] rr_q;
    logic [1:0] call_teller_q;
    logic       call_valid_q;
    logic       pop_q;
    logic [2:0] busy_q;
    logic [1:0] active_q;
    logic       no_service_q;

    logic [2:0] free;
    logic       eligible;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    logic [2:0] to_fire;
    logic [2:0] busy_rel;
    logic       grant;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    assign free     = teller_open & ~busy_q;
    assign eligible = (queue_count != 3'd0) && (|free);
    assign grant    = (state_q == CALL) && call_ack;
    assign busy_rel = busy_q & ~teller_done & ~to_fire;

    // First free desk scanning rr_q, rr_q+1, rr_q+2 modulo 3.
    always_comb begin
        pick  = rr_q;
        found = 1'b0;
        idx   = rr_q;
        for (int j = 0; j < 3; j++) begin
            if (!found && free[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = inc3(idx);
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_SERVICE + 1);

    logic [CNT_W-1:0] cnt_q [3];
    logic [2:0]       timeout_q;

    always_comb begin
        to_fire = 3'b000;
        for (int i = 0; i < 3; i++) begin
            to_fire[i] = busy_q[i] && (cnt_q[i] == CNT_W'(MAX_SERVICE)) && !teller_done[i];
        end
    end

    // Counters restart on grant and saturate so a stuck desk keeps firing nothing extra.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            timeout_q <= 3'b000;
        end else begin
            timeout_q <= to_fire;
            for (int i = 0; i < 3; i++) begin
                if (grant && (call_teller_q == 2'(i))) begin
                    cnt_q[i] <= '0;
                end else if (busy_q[i] && (cnt_q[i] != CNT_W'(MAX_SERVICE))) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign to_fire = 3'b000;
    assign timeout = 3'b000;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_q          <= 2'd0;
            call_teller_q <= 2'd0;
            call_valid_q  <= 1'b0;
            pop_q         <= 1'b0;
            busy_q        <= 3'b000;
            active_q      <= 2'd0;
            no_service_q  <= 1'b0;
        end else begin
            active_q     <= 2'({1'b0, teller_open[0]} + {1'b0, teller_open[1]} + {1'b0, teller_open[2]});
            no_service_q <= (queue_count != 3'd0) && (teller_open == 3'b000);
            pop_q        <= 1'b0;
            busy_q       <= busy_rel;
            case (state_q)
                IDLE: begin
                    if (eligible) begin
                        state_q       <= CALL;
                        call_valid_q  <= 1'b1;
                        call_teller_q <= pick;
                    end
                end
                CALL: begin
                    if (call_ack) begin
                        state_q      <= HOLD;
                        call_valid_q <= 1'b0;
                        pop_q        <= 1'b1;
                        busy_q       <= busy_rel | (3'b001 << call_teller_q);
                        rr_q         <= inc3(call_teller_q);
                    end else if (!teller_open[call_teller_q] || (queue_count == 3'd0)) begin
                        state_q      <= IDLE;
                        call_valid_q <= 1'b0;
                    end
                end
                // One dead cycle so the upstream counter reflects the pop before re-evaluating.
                HOLD: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign call_valid     = call_valid_q;
    assign call_teller    = call_teller_q;
    assign pop            = pop_q;
    assign teller_busy    = busy_q;
    assign active_tellers = active_q;
    assign no_service     = no_service_q;

endmodule

// File: tb/tb_teller_dispatcher.sv
// Randomized and directed stimulus for teller_dispatcher against a desk-level reference model.
module tb_teller_dispatcher;

    localparam int MAXS = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] queue_count = 3'd0;
    logic [2:0] teller_open = 3'd0;
    logic [2:0] teller_done = 3'd0;
    logic       call_ack = 1'b0;
    logic       call_valid;
    logic [1:0] call_teller;
    logic       pop;
    logic [2:0] teller_busy;
    logic [1:0] active_tellers;
    logic       no_service;
    logic [2:0] timeout;

    teller_dispatcher #(.MAX_SERVICE(MAXS)) dut (
        .clk(clk), .reset(reset), .queue_count(queue_count), .teller_open(teller_open),
        .teller_done(teller_done), .call_ack(call_ack), .call_valid(call_valid),
        .call_teller(call_teller), .pop(pop), .teller_busy(teller_busy),
        .active_tellers(active_tellers), .no_service(no_service), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int pops = 0;
    int to0 = 0;

    // Reference model: desk being called (-1 = none), pop owed, per-desk occupancy and age.
    int       m_call;
    int       m_teller;
    bit       m_pop;
    bit [2:0] m_busy;
    bit [2:0] m_to;
    int       m_age [3];
    int       m_ptr;
    int       m_active;
    bit       m_nosvc;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_call = -1; m_teller = 0; m_pop = 0; m_busy = 0; m_to = 0; m_ptr = 0;
        m_active = 0; m_nosvc = 0;
        for (int i = 0; i < 3; i++) m_age[i] = 0;
    endtask

    task automatic model_step();
        int       nc;
        int       g;
        bit       np;
        bit       found;
        bit       fire;
        bit [2:0] nb;
        nc = m_call; np = 0; g = -1; found = 0;
        if (m_call >= 0) begin
            if (call_ack) begin
                g = m_call; np = 1; nc = -1; m_ptr = (m_call + 1) % 3;
            end else if (!teller_open[m_call] || queue_count == 0) begin
                nc = -1;
            end
        end else if (!m_pop && queue_count != 0) begin
            for (int j = 0; j < 3; j++) begin
                int d;
                d = (m_ptr + j) % 3;
                if (!found && teller_open[d] && !m_busy[d]) begin
                    nc = d; m_teller = d; found = 1;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            fire = 0;
`ifdef DISPATCH_TIMEOUT_EN
            fire = m_busy[i] && (m_age[i] == MAXS) && !teller_done[i];
`endif
            nb[i]   = m_busy[i] && !teller_done[i] && !fire;
            m_to[i] = fire;
            if (g == i) begin
                nb[i] = 1; m_age[i] = 0;
            end else if (m_busy[i] && m_age[i] < MAXS) begin
                m_age[i]++;
            end
        end
        m_busy   = nb;
        m_call   = nc;
        m_pop    = np;
        m_active = $countones(teller_open);
        m_nosvc  = (queue_count != 0) && (teller_open == 0);
    endtask

    task automatic compare();
        chk("call_valid", int'(call_valid), int'(m_call >= 0));
        chk("call_teller", int'(call_teller), m_teller);
        chk("pop", int'(pop), int'(m_pop));
        chk("teller_busy", int'(teller_busy), int'(m_busy));
        chk("active_tellers", int'(active_tellers), m_active);
        chk("no_service", int'(no_service), int'(m_nosvc));
        chk("timeout", int'(timeout), int'(m_to));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        compare();
        if (pop) pops++;
        if (timeout[0]) to0++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must drop before the next edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_async_valid", int'(call_valid), 0);
        chk("rst_async_pop", int'(pop), 0);
        chk("rst_async_busy", int'(teller_busy), 0);
        model_reset();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        cycle();
        reset = 1'b0;
        chk("reset_valid", int'(call_valid), 0);
        chk("reset_busy", int'(teller_busy), 0);

        // Three back-to-back calls round-robin across all desks.
        queue_count = 3'd3; teller_open = 3'b111; call_ack = 1'b1; pops = 0;
        run(12);
        chk("s1_pops", pops, 3);
        chk("s1_busy", int'(teller_busy), 7);
        chk("s1_no_fourth", int'(call_valid), 0);

        // Done on desk 0 frees it for the next call.
        call_ack = 1'b0; queue_count = 3'd2; teller_done = 3'b001;
        cycle();
        teller_done = 3'b000;
        cycle();
        chk("s4_valid", int'(call_valid), 1);
        chk("s4_teller", int'(call_teller), 0);

        // Called desk closes before ack: cancel, pointer stays, next goes to desk 2.
        do_reset();
        queue_count = 3'd1; teller_open = 3'b111; call_ack = 1'b1;
        run(2);
        call_ack = 1'b0;
        run(2);
        chk("s2_called1", int'(call_teller), 1);
        teller_open = 3'b101; pops = 0;
        cycle();
        chk("s2_cancel", int'(call_valid), 0);
        cycle();
        chk("s2_next_valid", int'(call_valid), 1);
        chk("s2_next_teller", int'(call_teller), 2);
        chk("s2_no_pop", pops, 0);

        // No open desks, then desk 2 opens.
        do_reset();
        teller_open = 3'b000; queue_count = 3'd5;
        run(2);
        chk("s3_no_service", int'(no_service), 1);
        chk("s3_active0", int'(active_tellers), 0);
        teller_open = 3'b100;
        cycle();
        chk("s3_active1", int'(active_tellers), 1);
        chk("s3_call2", int'(call_teller), 2);

        // Reset during HOLD, then first call goes to desk 0.
        do_reset();
        queue_count = 3'd1; teller_open = 3'b111; call_ack = 1'b1;
        run(2);
        chk("s6_hold_pop", int'(pop), 1);
        do_reset();
        cycle();
        chk("s6_first_valid", int'(call_valid), 1);
        chk("s6_first_teller", int'(call_teller), 0);

        // Desk 0 never finishes.
        do_reset();
        queue_count = 3'd1; teller_open = 3'b001; call_ack = 1'b1;
        run(2);
        call_ack = 1'b0; to0 = 0;
        run(20);
`ifdef DISPATCH_TIMEOUT_EN
        chk("s5_timeout_pulses", to0, 1);
`else
        chk("s5_busy_held", int'(teller_busy[0]), 1);
        chk("s5_no_timeout", to0, 0);
`endif

        for (int c = 0; c < 3000; c++) begin
            queue_count = ($urandom % 4 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            if ($urandom % 10 == 0) teller_open = 3'($urandom);
            for (int i = 0; i < 3; i++) teller_done[i] = ($urandom % 8 == 0);
            call_ack = 1'($urandom % 2);
            if ($urandom % 400 == 0) do_reset();
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/teller_dispatcher.md
# teller_dispatcher

Round-robin dispatcher that calls the customer at the head of the bank queue to a free, open teller desk. Sits between the queue occupancy counter (people waiting, 0..7) and three teller desks. It drives the "next customer to desk N" display handshake, pulses a pop to decrement the queue, and tracks per-teller busy state. It also reports the number of open tellers to the wait-time lookup.

## Interface

- `MAX_SERVICE`, default 255: service-cycle limit per customer before forced release (timeout feature only); range 1..65535.
- `CNT_W`, default `$clog2(MAX_SERVICE+1)`: service counter width; derived, not overridden.

- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clock `clk`.
- `queue_count` in 3: customers waiting, from queue counter.
- `teller_open` in 3: bit i = desk i staffed.
- `teller_done` in 3: bit i = one-cycle pulse, desk i finished its customer.
- `call_ack` in 1: customer has left the queue head toward the called desk.
- `call_valid` out 1: call displayed; held until ack or cancel.
- `call_teller` out 2: desk number 0..2; stable while `call_valid`=1.
- `pop` out 1: one-cycle pulse, decrement queue.
- `teller_busy` out 3: bit i = desk i serving a customer.
- `active_tellers` out 2: popcount of `teller_open`, registered.
- `no_service` out 1: registered (`queue_count`!=0 && `teller_open`==0).
- `timeout` out 3: bit i = one-cycle pulse, desk i force-released.

## Operation

- Reset: state IDLE, rr_ptr=0, all outputs 0, all service counters 0.
- Free desk i: `teller_open[i]` && !`teller_busy[i]`.
- Eligible: `queue_count`!=0 and at least one free desk.
- FSM states:
  - IDLE
    - When eligible, go to CALL.
    - Latch `call_teller` = first free desk searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - CALL
    - `call_valid`=1.
    - If `call_ack`=1, go to HOLD. The same edge sets `teller_busy[call_teller]`, sets rr_ptr=(call_teller+1) mod 3, and clears the service counter.
    - Otherwise, if `teller_open[call_teller]`=0 or `queue_count`=0, cancel and go to IDLE. No pop; rr_ptr unchanged.
    - Ack has priority over cancel on the same edge.
  - HOLD
    - `pop`=1 for exactly this one cycle, then go to IDLE.
    - Lets the upstream counter update before re-evaluation.
- Busy release:
  - `teller_done[i]` clears `teller_busy[i]`.
  - Done on a non-busy desk is ignored.
  - A desk closing while busy stays busy until done or timeout.
- `call_ack` outside CALL is ignored.
- Widths:
  - rr_ptr is 2 bits, values 0..2 only; wrap 2→0.
  - Service counters saturate at `MAX_SERVICE`.

## Timing

- Eligibility is sampled at edge k. `call_valid` rises after edge k.
- `call_ack` is sampled at edge m with `call_valid`=1. After edge m, `call_valid`=0 and `pop`=1 and `teller_busy[call_teller]`=1, all in the same cycle. `pop` drops after edge m+1.
- Minimum call spacing is 3 cycles (IDLE, CALL with ack already high, HOLD).
- `teller_done` at edge n: busy bit clears after edge n, so the desk is eligible at edge n+1.
- `active_tellers` and `no_service` have 1-cycle latency from their inputs.
- Asynchronous `reset` mid-CALL/HOLD: `call_valid` and `pop` drop immediately; no pop is generated.

## Configuration

- `DISPATCH_TIMEOUT_EN` defined:
  - Each busy desk increments its counter every cycle.
  - When the counter equals `MAX_SERVICE` and no done arrives that cycle, the busy bit clears and `timeout[i]` pulses for 1 cycle. The desk becomes eligible next edge.
  - A done arriving in that same cycle wins; no timeout pulse.
- Not defined:
  - Counters are not instantiated and `timeout` is tied 0.
  - Busy clears only on `teller_done`.

## Test plan

- Reset, `queue_count`=3, `teller_open`=3'b111, `call_ack` 1 cycle after `call_valid` → calls to desks 0,1,2 in order. `pop` occurs 3 times and `teller_busy` ends at 3'b111. No fourth call is made until a `teller_done`.
- Desk 1 closes while called (`call_valid`=1, `call_teller`=1, no ack) → cancel and no pop. Next call goes to desk 2, with rr_ptr unchanged at 1.
- `teller_open`=3'b000, `queue_count`=5 → `no_service`=1 and `active_tellers`=0, with no call. Then open desk 2 → `active_tellers`=1 and a call to desk 2.
- `teller_done[0]` pulse when `teller_busy`=3'b111 and `queue_count`=2 → desk 0 is called on the following IDLE. A done on idle desk 2 has no effect.
- With `DISPATCH_TIMEOUT_EN` and `MAX_SERVICE`=4: desk 0 is granted and never sends done → `timeout[0]` pulses and `teller_busy[0]` clears. The same stimulus without the macro keeps `teller_busy[0]`=1 indefinitely.
- Assert `reset` in the HOLD cycle → `pop` drops immediately. All outputs read 0 and the first call after release targets desk 0.
